// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned W       = 32,
    parameter int unsigned W_FUNCT = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [W_FUNCT-1:0] op;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [W-1:0]       result;
    logic [W-1:0]       hi;
    logic [W-1:0]       lo;
    logic               done;
    logic               div_by_zero;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, result, hi, lo, done, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, result, hi, lo, done, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; MFxx/MTxx complete in one cycle.
module mult_div_unit #(
    parameter int unsigned W       = 32,
    parameter int unsigned W_FUNCT = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(W);
    localparam logic [W_FUNCT-1:0] OP_MFHI  = W_FUNCT'(8'h10);
    localparam logic [W_FUNCT-1:0] OP_MTHI  = W_FUNCT'(8'h11);
    localparam logic [W_FUNCT-1:0] OP_MFLO  = W_FUNCT'(8'h12);
    localparam logic [W_FUNCT-1:0] OP_MTLO  = W_FUNCT'(8'h13);
    localparam logic [W_FUNCT-1:0] OP_MULT  = W_FUNCT'(8'h18);
    localparam logic [W_FUNCT-1:0] OP_MULTU = W_FUNCT'(8'h19);
    localparam logic [W_FUNCT-1:0] OP_DIV   = W_FUNCT'(8'h1A);
    localparam logic [W_FUNCT-1:0] OP_DIVU  = W_FUNCT'(8'h1B);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opnd_q, a_q, hi_q, lo_q;
    logic            is_div_q, neg_q, neg_rem_q, dz_q;
    logic            done_q, dbz_q, ready_q;

    logic            accept, op_muldiv, op_div, op_signed, a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      mul_sum, div_trial;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quot_fix, rem_fix;

    always_comb begin
        accept    = bus.in_valid & ready_q;
        op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        op_muldiv = op_div || (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_neg     = op_signed & bus.a[W-1];
        b_neg     = op_signed & bus.b[W-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;

        // acc holds {partial, multiplier} for MUL and {remainder, quotient} for DIV
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        div_trial = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
        if (is_div_q) begin
            acc_d = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                 : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
        end

        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    if (accept) begin
                        if (bus.op == OP_MTHI) hi_q <= bus.a;
                        if (bus.op == OP_MTLO) lo_q <= bus.a;
                        if (op_muldiv) begin
                            state_q   <= S_RUN;
                            ready_q   <= 1'b0;
                            dbz_q     <= 1'b0;
                            cnt_q     <= CW'(W - 1);
                            is_div_q  <= op_div;
                            neg_q     <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            dz_q      <= op_div && (bus.b == '0);
                            a_q       <= bus.a;
                            opnd_q    <= op_div ? b_mag : a_mag;
                            acc_q     <= {{W{1'b0}}, (op_div ? a_mag : b_mag)};
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) state_q <= S_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else if (dz_q) begin
                        hi_q  <= a_q;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.result      = (bus.op == OP_MFHI) ? hi_q :
                             (bus.op == OP_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, monitor checks every done pulse.
module tb_mult_div_unit;
    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
    localparam logic [5:0] NOP = 6'h3F;

    logic clk, rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    logic [31:0] prev_hi, prev_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    mult_div_unit_if #(.W(32), .W_FUNCT(6)) ifc ();

    mult_div_unit #(.W(32), .W_FUNCT(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && ifc.done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("hi", {32'd0, ifc.hi}, {32'd0, e.hi});
                check("lo", {32'd0, ifc.lo}, {32'd0, e.lo});
                check("div_by_zero", {63'd0, ifc.div_by_zero}, {63'd0, e.dbz});
            end
        end
    end

    // Called at a negedge; drives one request across the next rising edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        ifc.in_valid = 1'b1;
        ifc.op       = op;
        ifc.a        = a;
        ifc.b        = b;
        @(posedge clk);
        #1;
        accept_cyc   = cyc;
        ifc.in_valid = 1'b0;
        ifc.op       = NOP;
    endtask

    task automatic start_op(input vec_t v);
        exp_t e;
        e.hi = v.hi; e.lo = v.lo; e.dbz = v.dbz;
        exp_q.push_back(e);
        prev_hi = ifc.hi;
        prev_lo = ifc.lo;
        issue(v.op, v.a, v.b);
    endtask

    task automatic wait_done();
        int  ready_bad = 0;
        int  hold_bad  = 0;
        bit  seen      = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ifc.done) begin
                seen = 1;
            end else begin
                if (ifc.in_ready) ready_bad++;
                if (ifc.hi !== prev_hi || ifc.lo !== prev_lo) hold_bad++;
            end
        end
        if (!seen) begin
            check("done_timeout", 64'd1, 64'd0);
        end else begin
            check("latency", 64'(cyc - accept_cyc + 1), 64'd34);
            check("ready_low_while_busy", 64'(ready_bad), 64'd0);
            check("hilo_hold_while_busy", 64'(hold_bad), 64'd0);
        end
    endtask

    vec_t vecs[] = '{
        '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0},
        '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0},
        '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
        '{DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0},
        '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0},
        '{DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0},
        '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0},
        '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0},
        '{DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1},
        '{MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0},
        '{DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1},
        '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0}
    };

    initial begin
        vec_t v;
        rst_n        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.op       = NOP;
        ifc.a        = '0;
        ifc.b        = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", {32'd0, ifc.hi}, 64'd0);
        check("rst_lo", {32'd0, ifc.lo}, 64'd0);
        check("rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);
        check("rst_done", {63'd0, ifc.done}, 64'd0);
        check("rst_dbz", {63'd0, ifc.div_by_zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            start_op(vecs[i]);
            wait_done();
            if (vecs[i].op == MULT && vecs[i].a == 32'hFFFFFFFD) begin
                @(negedge clk);
                ifc.op = MFLO;
                #1 check("mflo_result", {32'd0, ifc.result}, 64'h00000000FFFFFFEB);
                ifc.op = MFHI;
                #1 check("mfhi_result", {32'd0, ifc.result}, 64'h00000000FFFFFFFF);
                ifc.op = MULT;
                #1 check("other_op_result", {32'd0, ifc.result}, 64'd0);
                ifc.op = NOP;
            end
            @(negedge clk);
        end

        // MTHI then MTLO on consecutive edges
        ifc.in_valid = 1'b1;
        ifc.op = MTHI; ifc.a = 32'hA5A5A5A5;
        @(posedge clk); #1;
        ifc.op = MTLO; ifc.a = 32'h5A5A5A5A;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0; ifc.op = NOP;
        @(negedge clk);
        check("mthi", {32'd0, ifc.hi}, 64'h00000000A5A5A5A5);
        check("mtlo", {32'd0, ifc.lo}, 64'h000000005A5A5A5A);
        check("mt_no_done", {63'd0, ifc.done}, 64'd0);

        // MTHI offered while busy must be dropped
        v = '{MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0};
        start_op(v);
        repeat (3) @(negedge clk);
        ifc.in_valid = 1'b1; ifc.op = MTHI; ifc.a = 32'hDEADBEEF;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0; ifc.op = NOP;
        check("mthi_ignored_busy", {32'd0, ifc.hi}, 64'h00000000A5A5A5A5);
        wait_done();
        @(negedge clk);

        // Reset in the middle of a multiply
        v = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        start_op(v);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_hi", {32'd0, ifc.hi}, 64'd0);
        check("midrst_lo", {32'd0, ifc.lo}, 64'd0);
        check("midrst_in_ready", {63'd0, ifc.in_ready}, 64'd1);
        check("midrst_done", {63'd0, ifc.done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("postrst_hi", {32'd0, ifc.hi}, 64'd0);
        check("postrst_lo", {32'd0, ifc.lo}, 64'd0);
        check("postrst_in_ready", {63'd0, ifc.in_ready}, 64'd1);

        // Back-to-back: DIVU accepted in the DONE cycle of a MULTU
        v = '{MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0};
        start_op(v);
        wait_done();
        v = '{DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        start_op(v);
        wait_done();
        @(negedge clk);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
